// File: rtl/md_sched.sv
// Multi-cycle MULT/DIV scheduler owning HI/LO: one op in flight, fixed latency, D-stage stall.
// Optional flush input is compiled in when MD_SCHED_ABORT_EN is defined.
module md_sched #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef MD_SCHED_ABORT_EN
  input  logic        abort,
`endif
  input  logic        E_start,
  input  logic [2:0]  E_mdop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md_use,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        MD_Stall
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        nocommit_q, nocommit_d;

  logic        flush;
  logic        is_mul, is_div;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, divisor, uq, ur, quo, rem;

`ifdef MD_SCHED_ABORT_EN
  assign flush = abort;
`else
  assign flush = 1'b0;
`endif

  assign is_mul = (E_mdop == OP_MULT) || (E_mdop == OP_MULTU);
  assign is_div = (E_mdop == OP_DIV)  || (E_mdop == OP_DIVU);

  // Product of the 64-bit sign extensions, taken mod 2^64, is the signed product.
  assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Signed divide done on magnitudes so MIN / -1 wraps to MIN without overflow trouble.
  assign a_neg   = (E_mdop == OP_DIV) && E_A[31];
  assign b_neg   = (E_mdop == OP_DIV) && E_B[31];
  assign ua      = a_neg ? (32'd0 - E_A) : E_A;
  assign ub      = b_neg ? (32'd0 - E_B) : E_B;
  assign divisor = (ub == 32'd0) ? 32'd1 : ub;
  assign uq      = ua / divisor;
  assign ur      = ua % divisor;
  assign quo     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem     = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmp_hi_d   = tmp_hi_q;
    tmp_lo_d   = tmp_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    nocommit_d = nocommit_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && E_start) begin
          if (is_mul) begin
            state_d    = S_RUN;
            cnt_d      = 4'(MUL_CYCLES - 1);
            tmp_hi_d   = (E_mdop == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
            tmp_lo_d   = (E_mdop == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
            nocommit_d = 1'b0;
          end else if (is_div) begin
            state_d    = S_RUN;
            cnt_d      = 4'(DIV_CYCLES - 1);
            tmp_hi_d   = rem;
            tmp_lo_d   = quo;
            nocommit_d = (E_B == 32'd0);
          end else if (E_mdop == OP_MTHI) begin
            hi_d = E_A;
          end else if (E_mdop == OP_MTLO) begin
            lo_d = E_A;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d    = S_IDLE;
          cnt_d      = 4'd0;
          tmp_hi_d   = 32'd0;
          tmp_lo_d   = 32'd0;
          nocommit_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          if (!nocommit_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      tmp_hi_q   <= 32'd0;
      tmp_lo_q   <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      nocommit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmp_hi_q   <= tmp_hi_d;
      tmp_lo_q   <= tmp_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      nocommit_q <= nocommit_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign Busy     = (state_q == S_RUN);
  assign MD_Stall = D_md_use & (Busy | (E_start & (is_mul | is_div)));

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched (abort scenario built when MD_SCHED_ABORT_EN is defined).
module tb_md_sched;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        E_start;
  logic [2:0]  E_mdop;
  logic [31:0] E_A, E_B;
  logic        D_md_use;
  logic [31:0] HI, LO;
  logic        Busy, MD_Stall;
`ifdef MD_SCHED_ABORT_EN
  logic        abort;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md_sched dut (
    .clk      (clk),
    .reset_n  (reset_n),
`ifdef MD_SCHED_ABORT_EN
    .abort    (abort),
`endif
    .E_start  (E_start),
    .E_mdop   (E_mdop),
    .E_A      (E_A),
    .E_B      (E_B),
    .D_md_use (D_md_use),
    .HI       (HI),
    .LO       (LO),
    .Busy     (Busy),
    .MD_Stall (MD_Stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then count Busy cycles (bounded); flags any HI/LO change before Busy falls.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output bit early);
    logic [31:0] h0, l0;
    h0 = HI; l0 = LO; early = 1'b0; cyc = 0;
    E_start = 1'b1; E_mdop = op; E_A = a; E_B = b;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (HI !== h0 || LO !== l0) early = 1'b1;
      step();
    end
    $display("op=%0d A=%h B=%h busy_cycles=%0d HI=%h LO=%h", op, a, b, cyc, HI, LO);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; E_start = 1'b0; E_mdop = 3'd0; E_A = 32'd0; E_B = 32'd0; D_md_use = 1'b0;
`ifdef MD_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h expected %h", HI, 32'd0); end
    checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h expected %h", LO, 32'd0); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    step(); step();
    reset_n = 1'b1;
    E_start = 1'b1; E_mdop = 3'd5; E_A = 32'hAAAA5555;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    checks++; if (HI !== 32'hAAAA5555) begin failures++; $display("FAIL pre_reset_mthi: got %h expected %h", HI, 32'hAAAA5555); end
    E_start = 1'b1; E_mdop = 3'd1; E_A = 32'd5; E_B = 32'd3;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midop_reset_busy: got %b expected 0", Busy); end
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL midop_reset_hi: got %h expected %h", HI, 32'd0); end
    checks++; if (LO !== 32'd0) begin failures++; $display("FAIL midop_reset_lo: got %h expected %h", LO, 32'd0); end
    #2 reset_n = 1'b1;
    repeat (8) step();
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL reset_no_commit: got HI=%h LO=%h expected 0/0", HI, LO); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_no_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_mult();
    int cyc; bit early;
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, cyc, early);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL mult_latency: got %0d expected 5", cyc); end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL mult_early_commit: got %b expected 0", early); end
    checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi: got %h expected %h", HI, 32'hFFFFFFFF); end
    checks++; if (LO !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo: got %h expected %h", LO, 32'hFFFFFFFE); end
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, cyc, early);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL multu_latency: got %0d expected 5", cyc); end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL multu_early_commit: got %b expected 0", early); end
    checks++; if (HI !== 32'h00000001) begin failures++; $display("FAIL multu_hi: got %h expected %h", HI, 32'h1); end
    checks++; if (LO !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo: got %h expected %h", LO, 32'hFFFFFFFE); end
    do_op(3'd1, 32'hFFFFFFFD, 32'd5, cyc, early);
    checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_neg: got HI=%h LO=%h expected ffffffff/fffffff1", HI, LO); end
  endtask

  task automatic test_div();
    int cyc; bit early;
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, cyc, early);
    checks++; if (cyc !== 10) begin failures++; $display("FAIL div_latency: got %0d expected 10", cyc); end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL div_early_commit: got %b expected 0", early); end
    checks++; if (LO !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo: got %h expected %h", LO, 32'hFFFFFFFD); end
    checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi: got %h expected %h", HI, 32'hFFFFFFFF); end
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, cyc, early);
    checks++; if (LO !== 32'h80000000 || HI !== 32'd0) begin failures++; $display("FAIL div_min_neg1: got HI=%h LO=%h expected 00000000/80000000", HI, LO); end
    do_op(3'd4, 32'd7, 32'd0, cyc, early);
    checks++; if (cyc !== 10) begin failures++; $display("FAIL divu_zero_latency: got %0d expected 10", cyc); end
    checks++; if (LO !== 32'h80000000 || HI !== 32'd0) begin failures++; $display("FAIL divu_zero_unchanged: got HI=%h LO=%h expected 00000000/80000000", HI, LO); end
    do_op(3'd4, 32'hFFFFFFFF, 32'd2, cyc, early);
    checks++; if (LO !== 32'h7FFFFFFF || HI !== 32'd1) begin failures++; $display("FAIL divu_big: got HI=%h LO=%h expected 00000001/7fffffff", HI, LO); end
    do_op(3'd3, 32'd7, 32'hFFFFFFFE, cyc, early);
    checks++; if (LO !== 32'hFFFFFFFD || HI !== 32'd1) begin failures++; $display("FAIL div_neg_divisor: got HI=%h LO=%h expected 00000001/fffffffd", HI, LO); end
  endtask

  task automatic test_stall();
    int n;
    D_md_use = 1'b1; E_start = 1'b1; E_mdop = 3'd3; E_A = 32'd100; E_B = 32'd7;
    #1;
    checks++; if (MD_Stall !== 1'b1) begin failures++; $display("FAIL stall_start_cycle: got %b expected 1", MD_Stall); end
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    #1;
    n = 0;
    while (MD_Stall === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n !== 10) begin failures++; $display("FAIL stall_busy_cycles: got %0d expected 10", n); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL stall_busy_end: got %b expected 0", Busy); end
    checks++; if (LO !== 32'd14 || HI !== 32'd2) begin failures++; $display("FAIL stall_div_result: got HI=%h LO=%h expected 00000002/0000000e", HI, LO); end
    D_md_use = 1'b0; E_start = 1'b1; E_mdop = 3'd1; E_A = 32'd3; E_B = 32'd4;
    #1;
    checks++; if (MD_Stall !== 1'b0) begin failures++; $display("FAIL nouse_start_stall: got %b expected 0", MD_Stall); end
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    #1;
    checks++; if (Busy !== 1'b1 || MD_Stall !== 1'b0) begin failures++; $display("FAIL nouse_busy_stall: got Busy=%b MD_Stall=%b expected 1/0", Busy, MD_Stall); end
    n = 0;
    while (Busy === 1'b1 && n < 40) begin n++; step(); end
    checks++; if (LO !== 32'd12 || HI !== 32'd0) begin failures++; $display("FAIL nouse_mult_result: got HI=%h LO=%h expected 00000000/0000000c", HI, LO); end
    D_md_use = 1'b1; E_start = 1'b1; E_mdop = 3'd5; E_A = 32'd0;
    #1;
    checks++; if (MD_Stall !== 1'b0) begin failures++; $display("FAIL mthi_no_stall: got %b expected 0", MD_Stall); end
    E_start = 1'b0; E_mdop = 3'd0; D_md_use = 1'b0;
  endtask

  task automatic test_mt();
    int n;
    E_start = 1'b1; E_mdop = 3'd5; E_A = 32'h12345678;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    checks++; if (HI !== 32'h12345678) begin failures++; $display("FAIL mthi_value: got %h expected %h", HI, 32'h12345678); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b expected 0", Busy); end
    E_start = 1'b1; E_mdop = 3'd6; E_A = 32'hCAFEBABE;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    checks++; if (LO !== 32'hCAFEBABE || HI !== 32'h12345678) begin failures++; $display("FAIL mtlo_value: got HI=%h LO=%h expected 12345678/cafebabe", HI, LO); end
    E_start = 1'b1; E_mdop = 3'd1; E_A = 32'd2; E_B = 32'd3;
    step();
    E_start = 1'b1; E_mdop = 3'd6; E_A = 32'hDEADBEEF;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    checks++; if (LO !== 32'hCAFEBABE || Busy !== 1'b1) begin failures++; $display("FAIL mtlo_while_busy: got LO=%h Busy=%b expected cafebabe/1", LO, Busy); end
    n = 0;
    while (Busy === 1'b1 && n < 40) begin n++; step(); end
    checks++; if (n !== 4) begin failures++; $display("FAIL mtlo_busy_remaining: got %0d expected 4", n); end
    checks++; if (LO !== 32'd6 || HI !== 32'd0) begin failures++; $display("FAIL mtlo_then_commit: got HI=%h LO=%h expected 00000000/00000006", HI, LO); end
  endtask

  task automatic test_ignore();
    int n;
    E_start = 1'b1; E_mdop = 3'd0; E_A = 32'h1111; E_B = 32'h2;
    step();
    E_mdop = 3'd7;
    step();
    E_start = 1'b0; E_mdop = 3'd1;
    step();
    E_mdop = 3'd0;
    checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd6) begin failures++; $display("FAIL ignore_idle: got Busy=%b HI=%h LO=%h expected 0/00000000/00000006", Busy, HI, LO); end
    E_start = 1'b1; E_mdop = 3'd3; E_A = 32'd100; E_B = 32'd7;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    step(); step();
    E_start = 1'b1; E_mdop = 3'd1; E_A = 32'hFFFFFFFF; E_B = 32'hFFFFFFFF;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin n++; step(); end
    checks++; if (n !== 7) begin failures++; $display("FAIL start_while_busy_latency: got %0d expected 7", n); end
    checks++; if (LO !== 32'd14 || HI !== 32'd2) begin failures++; $display("FAIL start_while_busy_result: got HI=%h LO=%h expected 00000002/0000000e", HI, LO); end
  endtask

`ifdef MD_SCHED_ABORT_EN
  task automatic test_abort();
    E_start = 1'b1; E_mdop = 3'd1; E_A = 32'd2; E_B = 32'd3;
    step();
    E_start = 1'b0; E_mdop = 3'd0;
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", Busy); end
    repeat (6) step();
    checks++; if (HI !== 32'd2 || LO !== 32'd14) begin failures++; $display("FAIL abort_hilo: got HI=%h LO=%h expected 00000002/0000000e", HI, LO); end
    abort = 1'b1; E_start = 1'b1; E_mdop = 3'd6; E_A = 32'h55;
    step();
    E_mdop = 3'd1;
    step();
    abort = 1'b0; E_start = 1'b0; E_mdop = 3'd0;
    checks++; if (LO !== 32'd14 || Busy !== 1'b0) begin failures++; $display("FAIL abort_blocks_start: got LO=%h Busy=%b expected 0000000e/0", LO, Busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mt();
    test_ignore();
`ifdef MD_SCHED_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
